// File: rtl/mem_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_bridge
// Brief    : Bridges the FemtoRV32 strobe/busy memory port to NUM_TARGETS
//            valid/ready peripheral channels with decode, timeout and error flag.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_bridge #(
    parameter int NUM_TARGETS    = 4,
    parameter int ADDR_WIDTH     = 25,
    parameter int DATA_WIDTH     = 32,
    parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TARGET_BASE =
        {25'h100_0000, 25'h0A0_0000, 25'h090_0000, 25'h080_0000},
    parameter logic [NUM_TARGETS*ADDR_WIDTH-1:0] TARGET_MASK =
        {25'h100_0000, 25'h0F0_0000, 25'h0F0_0000, 25'h0F0_0000},
    parameter int TIMEOUT_CYCLES = 1023,
    parameter logic [DATA_WIDTH-1:0] ERROR_RDATA = 32'hDEAD_BEEF
) (
    input  logic                              clk,
    input  logic                              resetn,
    input  logic [31:0]                       mem_addr,
    input  logic [DATA_WIDTH-1:0]             mem_wdata,
    input  logic [DATA_WIDTH/8-1:0]           mem_wmask,
    input  logic                              mem_rstrb,
    output logic [DATA_WIDTH-1:0]             mem_rdata,
    output logic                              mem_rbusy,
    output logic                              mem_wbusy,
    output logic [NUM_TARGETS-1:0]            t_valid,
    output logic [ADDR_WIDTH-1:0]             t_addr,
    output logic [DATA_WIDTH-1:0]             t_wdata,
    output logic [DATA_WIDTH/8-1:0]           t_wmask,
    input  logic [NUM_TARGETS*DATA_WIDTH-1:0] t_rdata,
    input  logic [NUM_TARGETS-1:0]            t_ready,
    output logic                              bus_error,
    output logic [ADDR_WIDTH-1:0]             err_addr,
    input  logic                              err_clear
);

    localparam int c_SEL_W  = (NUM_TARGETS > 1) ? $clog2(NUM_TARGETS) : 1;
    localparam int c_CNT_W  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam int c_MASK_W = DATA_WIDTH / 8;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACTIVE = 2'd1,
        S_ERROR  = 2'd2
    } state_t;

    state_t                   r_state;
    state_t                   w_state_nxt;
    logic [NUM_TARGETS-1:0]   r_valid;
    logic [c_SEL_W-1:0]       r_sel;
    logic                     r_write;
    logic [ADDR_WIDTH-1:0]    r_addr;
    logic [DATA_WIDTH-1:0]    r_wdata;
    logic [c_MASK_W-1:0]      r_wmask;
    logic [DATA_WIDTH-1:0]    r_rdata;
    logic                     r_err;
    logic [ADDR_WIDTH-1:0]    r_err_addr;
    logic [c_CNT_W-1:0]       r_tcnt;

    logic [NUM_TARGETS-1:0]   w_match;
    logic                     w_hit;
    logic [c_SEL_W-1:0]       w_sel;
    logic                     w_wr;
    logic                     w_start;
    logic                     w_accept;
    logic                     w_ready_hit;
    logic                     w_timeout;
    logic                     w_err_set;
    logic [c_CNT_W-1:0]       w_tcnt_nxt;
    logic [DATA_WIDTH-1:0]    w_sel_rdata;

    assign w_wr        = |mem_wmask;
    assign w_start     = mem_rstrb | w_wr;
    assign w_tcnt_nxt  = r_tcnt + 1'b1;
    assign w_sel_rdata = t_rdata[r_sel*DATA_WIDTH +: DATA_WIDTH];

    generate
        if (ADDR_WIDTH < 32) begin : g_unused_addr
            logic w_unused_addr;
            assign w_unused_addr = &{1'b0, mem_addr[31:ADDR_WIDTH]};
        end
    endgenerate

    genvar gi;
    generate
        for (gi = 0; gi < NUM_TARGETS; gi++) begin : g_decode
            assign w_match[gi] =
                ((mem_addr[ADDR_WIDTH-1:0] & TARGET_MASK[gi*ADDR_WIDTH +: ADDR_WIDTH])
                 == TARGET_BASE[gi*ADDR_WIDTH +: ADDR_WIDTH]);
        end
    endgenerate

    // Scan downwards so the lowest matching index is the one left standing.
    always_comb begin
        w_hit = 1'b0;
        w_sel = '0;
        for (int i = NUM_TARGETS - 1; i >= 0; i--) begin
            if (w_match[i]) begin
                w_hit = 1'b1;
                w_sel = c_SEL_W'(i);
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // A ready drops valid at once; the state lingers one cycle in ACTIVE with
    // valid low so the CPU sees busy fall together with fresh read data.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_ready_hit = 1'b0;
        w_timeout   = 1'b0;
        w_err_set   = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_accept    = 1'b1;
                    w_state_nxt = w_hit ? S_ACTIVE : S_ERROR;
                end
            end
            S_ACTIVE: begin
                if (!(|r_valid)) begin
                    w_state_nxt = S_IDLE;
                end else if (t_ready[r_sel]) begin
                    w_ready_hit = 1'b1;
                end else if ((TIMEOUT_CYCLES != 0) &&
                             (w_tcnt_nxt == c_CNT_W'(TIMEOUT_CYCLES))) begin
                    w_timeout   = 1'b1;
                    w_err_set   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
            end
            S_ERROR: begin
                w_err_set   = 1'b1;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_valid    <= '0;
            r_sel      <= '0;
            r_write    <= 1'b0;
            r_addr     <= '0;
            r_wdata    <= '0;
            r_wmask    <= '0;
            r_rdata    <= '0;
            r_err      <= 1'b0;
            r_err_addr <= '0;
            r_tcnt     <= '0;
        end else begin
            if (w_accept) begin
                r_addr  <= mem_addr[ADDR_WIDTH-1:0];
                r_wdata <= mem_wdata;
                r_wmask <= w_wr ? mem_wmask : '0;
                r_write <= w_wr;
                r_sel   <= w_sel;
                r_valid <= w_hit ? (NUM_TARGETS'(1) << w_sel) : '0;
                r_tcnt  <= '0;
            end else if (r_state == S_ACTIVE && (|r_valid)) begin
                r_tcnt <= w_tcnt_nxt;
            end

            if (w_ready_hit || w_timeout) begin
                r_valid <= '0;
            end

            if (w_ready_hit && !r_write) begin
                r_rdata <= w_sel_rdata;
            end else if (w_err_set && !r_write) begin
                r_rdata <= ERROR_RDATA;
            end

            // Clear beats a same-cycle error; only the first error keeps its address.
            if (err_clear) begin
                r_err      <= 1'b0;
                r_err_addr <= '0;
            end else if (w_err_set) begin
                r_err <= 1'b1;
                if (!r_err) begin
                    r_err_addr <= r_addr;
                end
            end
        end
    end

    assign mem_rbusy = (r_state != S_IDLE) & ~r_write;
    assign mem_wbusy = (r_state != S_IDLE) &  r_write;
    assign mem_rdata = r_rdata;
    assign t_valid   = r_valid;
    assign t_addr    = r_addr;
    assign t_wdata   = r_wdata;
    assign t_wmask   = r_wmask;
    assign bus_error = r_err;
    assign err_addr  = r_err_addr;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_bridge.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_bus_bridge
// Brief    : Scoreboard bench for mem_bus_bridge using directed accesses.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_bridge;

    logic          clk;
    logic          resetn;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wmask;
    logic          mem_rstrb;
    logic [31:0]   mem_rdata;
    logic          mem_rbusy;
    logic          mem_wbusy;
    logic [3:0]    t_valid;
    logic [24:0]   t_addr;
    logic [31:0]   t_wdata;
    logic [3:0]    t_wmask;
    logic [127:0]  t_rdata;
    logic [3:0]    t_ready;
    logic          bus_error;
    logic [24:0]   err_addr;
    logic          err_clear;

    mem_bus_bridge #(
        .NUM_TARGETS    (4),
        .ADDR_WIDTH     (25),
        .DATA_WIDTH     (32),
        .TARGET_BASE    ({25'h100_0000, 25'h080_0000, 25'h090_0000, 25'h080_0000}),
        .TARGET_MASK    ({25'h100_0000, 25'h080_0000, 25'h0F0_0000, 25'h0F0_0000}),
        .TIMEOUT_CYCLES (8),
        .ERROR_RDATA    (32'hDEAD_BEEF)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wmask (mem_wmask),
        .mem_rstrb (mem_rstrb),
        .mem_rdata (mem_rdata),
        .mem_rbusy (mem_rbusy),
        .mem_wbusy (mem_wbusy),
        .t_valid   (t_valid),
        .t_addr    (t_addr),
        .t_wdata   (t_wdata),
        .t_wmask   (t_wmask),
        .t_rdata   (t_rdata),
        .t_ready   (t_ready),
        .bus_error (bus_error),
        .err_addr  (err_addr),
        .err_clear (err_clear)
    );

    typedef struct {
        logic [3:0]  valid;
        logic [24:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        int          vcyc;
    } req_t;

    typedef struct {
        int          rcyc;
        int          wcyc;
        logic [31:0] rdata;
        logic        err;
        logic [24:0] eaddr;
    } cmp_t;

    req_t req_q[$];
    cmp_t cmp_q[$];
    int   tests    = 0;
    int   failed   = 0;
    int   done_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_evt(input string name);
        tests++;
        failed++;
        $display("FAIL %s: event occurred with no expectation queued", name);
    endtask

    // Monitor: pops expectations when a request appears and when busy falls.
    initial begin : monitor
        req_t cur_req;
        cmp_t cur_cmp;
        logic prev_v = 1'b0;
        logic prev_b = 1'b0;
        int   vcnt   = 0;
        int   rcnt   = 0;
        int   wcnt   = 0;
        cur_req = '{4'b0, 25'b0, 32'b0, 4'b0, 0};
        forever begin
            @(negedge clk);
            if (t_valid != 4'b0) begin
                if (!prev_v) begin
                    if (req_q.size() == 0) begin
                        fail_evt("unexpected_t_valid");
                    end else begin
                        cur_req = req_q.pop_front();
                        chk("t_valid", 64'(t_valid), 64'(cur_req.valid));
                        chk("t_addr",  64'(t_addr),  64'(cur_req.addr));
                        chk("t_wdata", 64'(t_wdata), 64'(cur_req.wdata));
                        chk("t_wmask", 64'(t_wmask), 64'(cur_req.wmask));
                    end
                    vcnt = 0;
                end
                vcnt++;
            end else if (prev_v) begin
                chk("valid_cycles", 64'(vcnt), 64'(cur_req.vcyc));
            end
            prev_v = (t_valid != 4'b0);

            if (mem_rbusy) rcnt++;
            if (mem_wbusy) wcnt++;
            if (!(mem_rbusy || mem_wbusy) && prev_b) begin
                if (cmp_q.size() == 0) begin
                    fail_evt("unexpected_completion");
                end else begin
                    cur_cmp = cmp_q.pop_front();
                    chk("rbusy_cycles", 64'(rcnt),      64'(cur_cmp.rcyc));
                    chk("wbusy_cycles", 64'(wcnt),      64'(cur_cmp.wcyc));
                    chk("mem_rdata",    64'(mem_rdata), 64'(cur_cmp.rdata));
                    chk("bus_error",    64'(bus_error), 64'(cur_cmp.err));
                    chk("err_addr",     64'(err_addr),  64'(cur_cmp.eaddr));
                end
                done_cnt++;
                rcnt = 0;
                wcnt = 0;
            end
            prev_b = mem_rbusy || mem_wbusy;
        end
    end

    task automatic wait_done(input int target, input int budget);
        int n = 0;
        while (done_cnt < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        chk("completion_seen", 64'(done_cnt >= target), 64'd1);
        repeat (2) @(negedge clk);
    endtask

    // Delays count negedges after the strobe cycle; 0 means never.
    task automatic access(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] wm,
                          input logic rs, input int rdly, input logic [3:0] rv,
                          input int idly, input logic [3:0] iv, input int ck, input int budget);
        int tgt;
        int maxk;
        tgt  = done_cnt + 1;
        maxk = 1;
        if (rdly > maxk) maxk = rdly;
        if (idly > maxk) maxk = idly;
        if (ck > maxk)   maxk = ck;
        @(negedge clk);
        mem_addr  = a;
        mem_wdata = wd;
        mem_wmask = wm;
        mem_rstrb = rs;
        for (int k = 1; k <= maxk; k++) begin
            @(negedge clk);
            if (k == 1) begin
                mem_rstrb = 1'b0;
                mem_wmask = 4'b0;
            end
            t_ready   = ((k == rdly) ? rv : 4'b0) | ((k == idly) ? iv : 4'b0);
            err_clear = (k == ck);
        end
        @(negedge clk);
        t_ready   = 4'b0;
        err_clear = 1'b0;
        wait_done(tgt, budget);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin : stimulus
        int tgt;
        resetn    = 1'b0;
        mem_addr  = 32'b0;
        mem_wdata = 32'b0;
        mem_wmask = 4'b0;
        mem_rstrb = 1'b0;
        t_ready   = 4'b0;
        err_clear = 1'b0;
        t_rdata   = {32'h7777_0003, 32'h0BAD_0BAD, 32'hCAFE_F00D, 32'h1234_5678};
        repeat (3) @(negedge clk);
        chk("rst_t_valid",   64'(t_valid),   64'd0);
        chk("rst_t_addr",    64'(t_addr),    64'd0);
        chk("rst_t_wdata",   64'(t_wdata),   64'd0);
        chk("rst_t_wmask",   64'(t_wmask),   64'd0);
        chk("rst_mem_rdata", 64'(mem_rdata), 64'd0);
        chk("rst_busy",      64'({mem_rbusy, mem_wbusy}), 64'd0);
        chk("rst_bus_error", 64'(bus_error), 64'd0);
        chk("rst_err_addr",  64'(err_addr),  64'd0);
        resetn = 1'b1;
        repeat (2) @(negedge clk);

        // Read target 0, ready two cycles after the strobe.
        req_q.push_back('{4'b0001, 25'h080_0010, 32'h0, 4'h0, 2});
        cmp_q.push_back('{3, 0, 32'h1234_5678, 1'b0, 25'h0});
        access(32'h0080_0010, 32'h0, 4'h0, 1'b1, 2, 4'b0001, 0, 4'b0, 0, 20);

        // Write target 1, ready in the first active cycle.
        req_q.push_back('{4'b0010, 25'h090_0004, 32'hA5A5_0F0F, 4'b0011, 1});
        cmp_q.push_back('{0, 2, 32'h1234_5678, 1'b0, 25'h0});
        access(32'h0090_0004, 32'hA5A5_0F0F, 4'b0011, 1'b0, 1, 4'b0010, 0, 4'b0, 0, 20);

        // Unmapped read.
        cmp_q.push_back('{1, 0, 32'hDEAD_BEEF, 1'b1, 25'h000_0040});
        access(32'h0000_0040, 32'h0, 4'h0, 1'b1, 0, 4'b0, 0, 4'b0, 0, 20);

        // Timeout on target 0; the first error address must survive.
        req_q.push_back('{4'b0001, 25'h080_0020, 32'h0, 4'h0, 8});
        cmp_q.push_back('{8, 0, 32'hDEAD_BEEF, 1'b1, 25'h000_0040});
        access(32'h0080_0020, 32'h0, 4'h0, 1'b1, 0, 4'b0, 0, 4'b0, 0, 40);

        @(negedge clk);
        err_clear = 1'b1;
        @(negedge clk);
        err_clear = 1'b0;
        chk("clr_bus_error", 64'(bus_error), 64'd0);
        chk("clr_err_addr",  64'(err_addr),  64'd0);

        // Unmapped write after clear: fresh capture, read data untouched.
        cmp_q.push_back('{0, 1, 32'hDEAD_BEEF, 1'b1, 25'h000_0080});
        access(32'h0000_0080, 32'h1111_2222, 4'hF, 1'b0, 0, 4'b0, 0, 4'b0, 0, 20);

        // Clear in the same cycle as a new error: clear wins.
        cmp_q.push_back('{1, 0, 32'hDEAD_BEEF, 1'b0, 25'h0});
        access(32'h0000_0100, 32'h0, 4'h0, 1'b1, 0, 4'b0, 0, 4'b0, 1, 20);

        // Overlapping decode, both strobes: write to target 1, stray ready on 2.
        req_q.push_back('{4'b0010, 25'h090_0008, 32'h5A5A_C3C3, 4'hF, 2});
        cmp_q.push_back('{0, 3, 32'hDEAD_BEEF, 1'b0, 25'h0});
        access(32'h0090_0008, 32'h5A5A_C3C3, 4'hF, 1'b1, 2, 4'b0010, 1, 4'b0100, 0, 20);

        // Read with ready in the first active cycle.
        req_q.push_back('{4'b0001, 25'h080_0044, 32'h0, 4'h0, 1});
        cmp_q.push_back('{2, 0, 32'h1234_5678, 1'b0, 25'h0});
        access(32'h0080_0044, 32'h0, 4'h0, 1'b1, 1, 4'b0001, 0, 4'b0, 0, 20);

        // Reset in the middle of an active read, then a late ready.
        req_q.push_back('{4'b0001, 25'h080_0050, 32'h0, 4'h0, 2});
        cmp_q.push_back('{2, 0, 32'h0, 1'b0, 25'h0});
        tgt = done_cnt + 1;
        @(negedge clk);
        mem_addr  = 32'h0080_0050;
        mem_rstrb = 1'b1;
        @(negedge clk);
        mem_rstrb = 1'b0;
        @(negedge clk);
        #2 resetn = 1'b0;
        #1;
        chk("async_rst_t_valid", 64'(t_valid),   64'd0);
        chk("async_rst_rbusy",   64'(mem_rbusy), 64'd0);
        wait_done(tgt, 10);
        @(negedge clk);
        resetn = 1'b1;
        @(negedge clk);
        t_ready = 4'b0001;
        @(negedge clk);
        t_ready = 4'b0;
        @(negedge clk);
        chk("late_ready_t_valid", 64'(t_valid),   64'd0);
        chk("late_ready_busy",    64'({mem_rbusy, mem_wbusy}), 64'd0);
        chk("late_ready_rdata",   64'(mem_rdata), 64'd0);

        chk("req_q_drained", 64'(req_q.size()), 64'd0);
        chk("cmp_q_drained", 64'(cmp_q.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
`default_nettype wire
